// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM request arbiter
package sram_arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int ATTR_AWIDTH = 20;
    localparam int ATTR_DWIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic                   write;
        logic [2:0]             size;
        logic [ATTR_AWIDTH-1:0] addr;
        logic [ATTR_DWIDTH-1:0] wdata;
    } req_attr_t;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// rtl/sram_arb_rr_pick.sv - combinational 2-way winner select (round-robin or fixed priority)
module sram_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output logic [1:0] grant
);

    // last = 1 means port 1 won the previous transaction, so port 0 takes a tie
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if (mode || last) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-port arbiter with watchdog in front of the SRAM controller
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ARB_MODE       = ARB_RR,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int AWIDTH         = ATTR_AWIDTH,
    parameter int DWIDTH         = ATTR_DWIDTH
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [2:0]        m0_size,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DWIDTH-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [2:0]        m1_size,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic              sram_req,
    output logic              sram_write,
    output logic [2:0]        sram_size,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [DWIDTH-1:0] sram_wdata,
    input  logic              sram_ack,
    input  logic [DWIDTH-1:0] sram_rdata,
    input  logic              sram_busy,
    output logic [1:0]        grant
);

    localparam int            CW         = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int            TMO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] TMO_LAST   = CW'(TMO_LAST_I);
    localparam logic          WD_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic          FIXED_PRIO = (ARB_MODE == ARB_FIXED);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [CW-1:0] wd_cnt;
    logic          last_win;
    logic [1:0]    pick;
    logic          start;
    logic          resp_load;
    logic          timeout;
    req_attr_t     m0_attr;
    req_attr_t     m1_attr;
    req_attr_t     win_attr;

    sram_arb_rr_pick u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last_win),
        .mode  (FIXED_PRIO),
        .grant (pick)
    );

    assign m0_attr  = '{write: m0_write, size: m0_size, addr: m0_addr, wdata: m0_wdata};
    assign m1_attr  = '{write: m1_write, size: m1_size, addr: m1_addr, wdata: m1_wdata};
    assign win_attr = pick[1] ? m1_attr : m0_attr;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A controller ack in the same WAIT cycle as the timeout takes precedence
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        resp_load = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (!sram_busy && (pick != 2'b00)) begin
                    start     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (sram_ack) begin
                    resp_load = 1'b1;
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (sram_ack) begin
                    resp_load = 1'b1;
                    state_nxt = RESP;
                end else if (WD_EN && (wd_cnt == TMO_LAST)) begin
                    resp_load = 1'b1;
                    timeout   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sram_req   <= 1'b0;
            sram_write <= 1'b0;
            sram_size  <= 3'b000;
            sram_addr  <= '0;
            sram_wdata <= '0;
            grant      <= 2'b00;
            last_win   <= 1'b1;
            wd_cnt     <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            sram_req <= start;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;

            if (start) begin
                sram_write <= win_attr.write;
                sram_size  <= win_attr.size;
                sram_addr  <= win_attr.addr;
                sram_wdata <= win_attr.wdata;
                grant      <= pick;
            end

            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if ((state == WAIT) && (wd_cnt != '1)) begin
                wd_cnt <= wd_cnt + CW'(1);
            end

            if (resp_load && grant[0]) begin
                m0_ack   <= 1'b1;
                m0_err   <= timeout;
                m0_rdata <= timeout ? '0 : sram_rdata;
            end
            if (resp_load && grant[1]) begin
                m1_ack   <= 1'b1;
                m1_err   <= timeout;
                m1_rdata <= timeout ? '0 : sram_rdata;
            end

            if (state == RESP) begin
                last_win <= grant[1];
                grant    <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - self-checking bench for sram_req_arbiter
module tb_sram_req_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    logic          m0_req = 1'b0, m1_req = 1'b0, m0_write = 1'b0, m1_write = 1'b0;
    logic [2:0]    m0_size = '0, m1_size = '0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          sram_busy = 1'b0;
    logic [DW-1:0] rsp_rdata = '0;
    int            ack_dly = -1;

    logic          a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_sram_req, a_sram_write;
    logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_sram_wdata;
    logic [2:0]    a_sram_size;
    logic [AW-1:0] a_sram_addr;
    logic [1:0]    a_grant;
    logic          a_sram_ack = 1'b0;

    logic          b_m0_ack, b_m1_ack, b_m0_err, b_m1_err, b_sram_req, b_sram_write;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_sram_wdata;
    logic [2:0]    b_sram_size;
    logic [AW-1:0] b_sram_addr;
    logic [1:0]    b_grant;
    logic          b_sram_ack = 1'b0;

    sram_req_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(8), .AWIDTH(AW), .DWIDTH(DW)) dut_rr (
        .HCLK(HCLK), .HRESET(HRESET),
        .m0_req(m0_req), .m0_write(m0_write), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(a_m0_ack), .m0_err(a_m0_err), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(a_m1_ack), .m1_err(a_m1_err), .m1_rdata(a_m1_rdata),
        .sram_req(a_sram_req), .sram_write(a_sram_write), .sram_size(a_sram_size),
        .sram_addr(a_sram_addr), .sram_wdata(a_sram_wdata),
        .sram_ack(a_sram_ack), .sram_rdata(rsp_rdata), .sram_busy(sram_busy), .grant(a_grant)
    );

    sram_req_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(8), .AWIDTH(AW), .DWIDTH(DW)) dut_fx (
        .HCLK(HCLK), .HRESET(HRESET),
        .m0_req(m0_req), .m0_write(m0_write), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
        .sram_req(b_sram_req), .sram_write(b_sram_write), .sram_size(b_sram_size),
        .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
        .sram_ack(b_sram_ack), .sram_rdata(rsp_rdata), .sram_busy(sram_busy), .grant(b_grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Controller model: ack ack_dly cycles after sram_req (0 = same cycle, <0 = never)
    int pend_a = -1;
    int pend_b = -1;
    always @(negedge HCLK) begin
        a_sram_ack = 1'b0;
        if (a_sram_req === 1'b1 && ack_dly >= 0) pend_a = ack_dly;
        if (pend_a == 0) a_sram_ack = 1'b1;
        if (pend_a >= 0) pend_a = pend_a - 1;
        b_sram_ack = 1'b0;
        if (b_sram_req === 1'b1 && ack_dly >= 0) pend_b = ack_dly;
        if (pend_b == 0) b_sram_ack = 1'b1;
        if (pend_b >= 0) pend_b = pend_b - 1;
    end

    typedef struct {
        int            port;
        logic          err;
        logic [DW-1:0] rdata;
    } sb_t;

    sb_t           sb_q[$];
    logic [DW-1:0] last_rd [2] = '{'0, '0};
    logic [1:0]    a_glog[$];
    logic [1:0]    b_glog[$];
    int            b_acks0 = 0;
    int            b_acks1 = 0;

    always @(negedge HCLK) begin : mon
        sb_t e;
        int  p;
        if (HRESET === 1'b0) begin
            if (a_sram_req) a_glog.push_back(a_grant);
            if (b_sram_req) b_glog.push_back(b_grant);
            if (b_m0_ack) b_acks0++;
            if (b_m1_ack) b_acks1++;
            if (a_m0_ack || a_m1_ack) begin
                chk("ack_onehot", 64'(a_m0_ack & a_m1_ack), 64'd0);
                chk("ack_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    p = a_m1_ack ? 1 : 0;
                    chk("ack_port", 64'(p), 64'(e.port));
                    chk("ack_err", 64'(p == 1 ? a_m1_err : a_m0_err), 64'(e.err));
                    chk("ack_rdata", 64'(p == 1 ? a_m1_rdata : a_m0_rdata), 64'(e.rdata));
                    chk("other_err", 64'(p == 1 ? a_m0_err : a_m1_err), 64'd0);
                    chk("other_rdata_hold", 64'(p == 1 ? a_m0_rdata : a_m1_rdata), 64'(last_rd[1-p]));
                    last_rd[e.port] = e.rdata;
                end
            end
        end
    end

    typedef struct {
        logic [1:0]    req;
        logic          write;
        logic [2:0]    size;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            ack_dly;
        logic [DW-1:0] rsp;
        logic [1:0]    exp_grant;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    task automatic apply_vec(input vec_t v, input string tag);
        bit got_req;
        bit got_ack;
        sb_t e;
        @(posedge HCLK); #1;
        ack_dly   = v.ack_dly;
        rsp_rdata = v.rsp;
        if (v.exp_grant[1]) begin
            m1_write = v.write;  m1_size = v.size;  m1_addr = v.addr;  m1_wdata = v.wdata;
            m0_write = ~v.write; m0_size = ~v.size; m0_addr = ~v.addr; m0_wdata = ~v.wdata;
        end else begin
            m0_write = v.write;  m0_size = v.size;  m0_addr = v.addr;  m0_wdata = v.wdata;
            m1_write = ~v.write; m1_size = ~v.size; m1_addr = ~v.addr; m1_wdata = ~v.wdata;
        end
        e.port  = v.exp_grant[1] ? 1 : 0;
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        sb_q.push_back(e);
        m0_req = v.req[0];
        m1_req = v.req[1];
        got_req = 0;
        got_ack = 0;
        for (int cyc = 0; cyc < 40 && !got_ack; cyc++) begin
            @(negedge HCLK);
            if (a_sram_req) begin
                got_req = 1;
                chk({tag, "_req_cycle"}, 64'(cyc), 64'd1);
                chk({tag, "_grant"}, 64'(a_grant), 64'(v.exp_grant));
                chk({tag, "_sram_write"}, 64'(a_sram_write), 64'(v.write));
                chk({tag, "_sram_size"}, 64'(a_sram_size), 64'(v.size));
                chk({tag, "_sram_addr"}, 64'(a_sram_addr), 64'(v.addr));
                chk({tag, "_sram_wdata"}, 64'(a_sram_wdata), 64'(v.wdata));
            end
            if (a_m0_ack || a_m1_ack) begin
                got_ack = 1;
                chk({tag, "_ack_cycle"}, 64'(cyc), 64'(v.exp_lat));
            end
        end
        chk({tag, "_req_seen"}, 64'(got_req), 64'd1);
        chk({tag, "_ack_seen"}, 64'(got_ack), 64'd1);
        if (!got_ack) sb_q.delete();
        @(posedge HCLK); #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge HCLK);
        chk({tag, "_grant_idle"}, 64'(a_grant), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        sram_busy = 1'b0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        sb_q.delete();
    endtask

    vec_t vt[8];
    vec_t v_pre;
    vec_t v_post;

    initial begin
        bit got;
        int n;
        int quiet;
        sb_t e;

        vt[0] = '{2'b01, 1'b0, 3'b010, 20'h00010, 32'h0,        2, 32'hDEADBEEF, 2'b01, 1'b0, 32'hDEADBEEF, 4};
        vt[1] = '{2'b10, 1'b1, 3'b000, 20'hFFFFF, 32'h000000A5, 0, 32'h0BADF00D, 2'b10, 1'b0, 32'h0BADF00D, 2};
        vt[2] = '{2'b01, 1'b0, 3'b010, 20'h00100, 32'h0,       -1, 32'h11111111, 2'b01, 1'b1, 32'h0,        10};
        vt[3] = '{2'b10, 1'b0, 3'b001, 20'h00200, 32'h0,        1, 32'h22222222, 2'b10, 1'b0, 32'h22222222, 3};
        vt[4] = '{2'b11, 1'b1, 3'b010, 20'h00300, 32'h33333333, 1, 32'h44444444, 2'b01, 1'b0, 32'h44444444, 3};
        vt[5] = '{2'b11, 1'b0, 3'b010, 20'h00400, 32'h0,        0, 32'h55555555, 2'b10, 1'b0, 32'h55555555, 2};
        vt[6] = '{2'b01, 1'b0, 3'b010, 20'h00500, 32'h0,        8, 32'h66666666, 2'b01, 1'b0, 32'h66666666, 10};
        vt[7] = '{2'b10, 1'b0, 3'b010, 20'h00600, 32'h0,        9, 32'h77777777, 2'b10, 1'b1, 32'h0,        10};
        v_pre  = '{2'b01, 1'b0, 3'b010, 20'h00700, 32'h0, 1, 32'h88888888, 2'b01, 1'b0, 32'h88888888, 3};
        v_post = '{2'b11, 1'b0, 3'b010, 20'h00800, 32'h0, 1, 32'h99999999, 2'b01, 1'b0, 32'h99999999, 3};

        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_grant", 64'(a_grant), 64'd0);
        chk("rst_sram_req", 64'(a_sram_req), 64'd0);
        chk("rst_sram_addr", 64'(a_sram_addr), 64'd0);
        chk("rst_sram_write", 64'(a_sram_write), 64'd0);
        chk("rst_acks", 64'({a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}), 64'd0);
        chk("rst_m0_rdata", 64'(a_m0_rdata), 64'd0);
        chk("rst_m1_rdata", 64'(a_m1_rdata), 64'd0);

        for (int i = 0; i < 8; i++) begin
            apply_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Both ports requesting continuously: RR alternates, fixed keeps port 0
        do_reset();
        a_glog.delete();
        b_glog.delete();
        b_acks0 = 0;
        b_acks1 = 0;
        ack_dly = 1;
        rsp_rdata = 32'hA5A50000;
        for (int i = 0; i < 6; i++) begin
            e.port = i % 2;
            e.err = 1'b0;
            e.rdata = 32'hA5A50000;
            sb_q.push_back(e);
        end
        m0_write = 1'b0; m0_size = 3'b010; m0_addr = 20'h10000; m0_wdata = '0;
        m1_write = 1'b0; m1_size = 3'b010; m1_addr = 20'h20000; m1_wdata = '0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 6; cyc++) begin
            @(negedge HCLK);
            if (a_m0_ack || a_m1_ack) n++;
        end
        @(posedge HCLK); #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("rr_ack_count", 64'(n), 64'd6);
        chk("rr_grant_count", 64'(a_glog.size()), 64'd6);
        for (int i = 0; i < 6 && i < a_glog.size(); i++) begin
            chk($sformatf("rr_grant%0d", i), 64'(a_glog[i]), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
        end
        chk("fx_grant_count", 64'(b_glog.size()), 64'd6);
        for (int i = 0; i < 6 && i < b_glog.size(); i++) begin
            chk($sformatf("fx_grant%0d", i), 64'(b_glog[i]), 64'd1);
        end
        chk("fx_m0_acks", 64'(b_acks0), 64'd6);
        chk("fx_m1_acks", 64'(b_acks1), 64'd0);

        // sram_busy blocks issue for 5 cycles
        @(posedge HCLK); #1;
        sram_busy = 1'b1;
        ack_dly = 1;
        rsp_rdata = 32'hC0FFEE00;
        m1_write = 1'b0; m1_size = 3'b010; m1_addr = 20'h00A00;
        e.port = 1;
        e.err = 1'b0;
        e.rdata = 32'hC0FFEE00;
        sb_q.push_back(e);
        m1_req = 1'b1;
        quiet = 0;
        repeat (5) begin
            @(negedge HCLK);
            quiet += int'(a_sram_req);
        end
        chk("busy_no_req", 64'(quiet), 64'd0);
        @(posedge HCLK); #1;
        sram_busy = 1'b0;
        @(negedge HCLK);
        chk("busy_fall_cycle_req", 64'(a_sram_req), 64'd0);
        @(negedge HCLK);
        chk("busy_release_req", 64'(a_sram_req), 64'd1);
        got = 0;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            @(negedge HCLK);
            if (a_m1_ack) got = 1;
        end
        chk("busy_ack_seen", 64'(got), 64'd1);
        if (!got) sb_q.delete();
        @(posedge HCLK); #1;
        m1_req = 1'b0;

        // Reset in WAIT aborts silently; pointer returns to port 0
        apply_vec(v_pre, "pre_reset");
        @(posedge HCLK); #1;
        ack_dly = 5;
        m0_addr = 20'h00900;
        m0_req = 1'b1;
        m1_req = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            @(negedge HCLK);
            if (a_sram_req) got = 1;
        end
        chk("rst_issue_seen", 64'(got), 64'd1);
        @(negedge HCLK);
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        m0_req = 1'b0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge HCLK);
        chk("wait_rst_grant", 64'(a_grant), 64'd0);
        chk("wait_rst_sram_req", 64'(a_sram_req), 64'd0);
        chk("wait_rst_sram_addr", 64'(a_sram_addr), 64'd0);
        chk("wait_rst_m0_rdata", 64'(a_m0_rdata), 64'd0);
        quiet = 0;
        repeat (6) begin
            @(negedge HCLK);
            quiet += int'(a_sram_req) + int'(a_m0_ack) + int'(a_m1_ack) + int'(a_grant != 2'b00);
        end
        chk("late_ack_ignored", 64'(quiet), 64'd0);
        apply_vec(v_post, "post_reset");

        repeat (2) @(negedge HCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
